muldiv_hilo_ctrl: RTL and testbench

Sequencing controller for the HI/LO register pair. It owns HI and LO and runs an iterative 32-cycle unsigned multiplier and restoring divider. It serves MTHI/MTLO writes and MFHI/MFLO reads, and stalls the pipeline whenever a HI/LO access collides with an operation still in flight. It sits beside the ALU and uses the same 4-bit op signal encoding.

---
 rtl/muldiv_hilo_ctrl_if.sv | 28 ++
 rtl/muldiv_hilo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_ctrl_if.sv
// HI/LO controller bus: op request from the pipeline, stall/busy back-pressure,
// MFHI/MFLO read data and the live HI/LO register values.
interface muldiv_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] dataout;
  logic             dataout_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: presents ops and operands, observes stall and results.
  modport master (
    output op_valid, op, src_a, src_b,
    input  stall, busy, dataout, dataout_valid, hi, lo
  );

  // Controller side: consumes ops, drives stall, busy and results.
  modport slave (
    input  op_valid, op, src_a, src_b,
    output stall, busy, dataout, dataout_valid, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO sequencing controller: owns HI and LO, runs a 32-step unsigned
// shift-add multiplier and restoring divider, and serves MTHI/MTLO/MFHI/MFLO.
// A single 2*WIDTH accumulator holds {partial product, multiplier} during MUL
// and {remainder, dividend/quotient} during DIV; the other operand lives in
// opnd_q (multiplicand or divisor).
module muldiv_hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_hilo_ctrl_if.slave bus
);

  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MTHI  = 4'b1011;
  localparam logic [3:0] OP_MTLO  = 4'b1100;

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dvalid_q, dvalid_d;

  logic               isHiLoOp;
  logic               accept;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [WIDTH:0]     divShift;
  logic [WIDTH:0]     divDiff;
  logic [2*WIDTH-1:0] divStep;

  // Decode the op and derive stall; no-op codes never stall.
  always_comb begin
    isHiLoOp = 1'b0;
    case (bus.op)
      OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO: isHiLoOp = 1'b1;
      default:                                              isHiLoOp = 1'b0;
    endcase
    bus.stall = bus.op_valid & (state_q != IDLE) & isHiLoOp;
    accept    = bus.op_valid & ~bus.stall;
  end

  // One iteration of each datapath: LSB-first shift-add and restoring divide.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mulStep  = {mulSum, acc_q[WIDTH-1:1]};
    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd_q};
    if (!divDiff[WIDTH]) begin
      divStep = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      divStep = {divShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic: accept ops in IDLE, step MUL/DIV, write HI/LO on the last step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            OP_MULTU: begin
              opnd_d  = bus.src_a;
              acc_d   = {{WIDTH{1'b0}}, bus.src_b};
              cnt_d   = '0;
              state_d = MUL;
            end
            OP_DIVU: begin
              opnd_d  = bus.src_b;
              acc_d   = {{WIDTH{1'b0}}, bus.src_a};
              cnt_d   = '0;
              state_d = DIV;
            end
            OP_MTHI: hi_d = bus.src_a;
            OP_MTLO: lo_d = bus.src_a;
            OP_MFHI: begin
              dout_d   = hi_q;
              dvalid_d = 1'b1;
            end
            OP_MFLO: begin
              dout_d   = lo_q;
              dvalid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mulStep;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          hi_d    = mulStep[2*WIDTH-1:WIDTH];
          lo_d    = mulStep[WIDTH-1:0];
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      DIV: begin
        acc_d = divStep;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          hi_d    = divStep[2*WIDTH-1:WIDTH];
          lo_d    = divStep[WIDTH-1:0];
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation without touching HI/LO beyond clearing them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.dataout       = dout_q;
  assign bus.dataout_valid = dvalid_q;
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Testbench for muldiv_hilo_ctrl: a table of IDLE-state ops with hand-computed
// HI/LO/dataout results, then hand-written sequences for stall-during-busy,
// no-op during MUL and reset mid-multiply.
module tb_muldiv_hilo_ctrl;

  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_MTHI  = 4'b1011;
  localparam logic [3:0] OP_MTLO  = 4'b1100;
  localparam logic [3:0] OP_NOP   = 4'b0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_hilo_ctrl #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDv;
    logic [31:0] expDout;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Presents one op for one cycle starting at posedge+1; returns at the next posedge+1.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
  endtask

  // Counts cycles until busy drops, bounded so a stuck DUT cannot hang the run.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int cycles;
    int stallCycles;
    int dvDuringBusy;

    checks = 0;
    errors = 0;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.src_a    = '0;
    bus.src_b    = '0;

    vecs[0]  = '{OP_MFHI,  32'h0,         32'h0,        32'h0,         32'h0,         1'b1, 32'h0};
    vecs[1]  = '{OP_MFLO,  32'h0,         32'h0,        32'h0,         32'h0,         1'b1, 32'h0};
    vecs[2]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,        32'h1,         32'hFFFF_FFFE, 1'b0, 32'h0};
    vecs[3]  = '{OP_MFLO,  32'h0,         32'h0,        32'h1,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE};
    vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 32'hFFFF_FFFE};
    vecs[5]  = '{OP_DIVU,  32'h1234_5678, 32'h0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE};
    vecs[6]  = '{OP_MTHI,  32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE};
    vecs[7]  = '{OP_MTLO,  32'hCAFE_F00D, 32'h0,        32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 32'hFFFF_FFFE};
    vecs[8]  = '{OP_MFHI,  32'h0,         32'h0,        32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{OP_MFLO,  32'h0,         32'h0,        32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[10] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1,        32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[11] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,        1'b0, 32'hCAFE_F00D};
    vecs[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, 1'b0, 32'hCAFE_F00D};
    vecs[13] = '{OP_DIVU,  32'd5,         32'd9,        32'd5,         32'd0,         1'b0, 32'hCAFE_F00D};

    // Reset state.
    rst_n = 1'b0;
    #12;
    checkOutput("rst hi", bus.hi, 32'h0);
    checkOutput("rst lo", bus.lo, 32'h0);
    checkOutput("rst dataout", bus.dataout, 32'h0);
    checkOutput("rst busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rst dv", {31'b0, bus.dataout_valid}, 32'h0);
    checkOutput("rst stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven ops, each issued from IDLE.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].op == OP_MULTU || vecs[i].op == OP_DIVU) begin
        waitDone(cycles);
        checkOutput($sformatf("v%0d busy cycles", i), 32'(cycles), 32'd32);
      end
      checkOutput($sformatf("v%0d hi", i), bus.hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d lo", i), bus.lo, vecs[i].expLo);
      checkOutput($sformatf("v%0d dv", i), {31'b0, bus.dataout_valid}, {31'b0, vecs[i].expDv});
      checkOutput($sformatf("v%0d dataout", i), bus.dataout, vecs[i].expDout);
    end

    // dataout_valid is a single-cycle pulse and dataout holds.
    @(posedge clk);
    #1;
    checkOutput("dv drops", {31'b0, bus.dataout_valid}, 32'h0);
    checkOutput("dataout holds", bus.dataout, 32'hCAFE_F00D);

    // DIVU 100/7 with MFHI held during busy: stalls until IDLE, then reads 2.
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    bus.op_valid = 1'b1;
    bus.op       = OP_MFHI;
    bus.src_a    = 32'h5555_5555;
    stallCycles  = 0;
    dvDuringBusy = 0;
    cycles       = 0;
    while (bus.busy && cycles < 100) begin
      if (bus.stall) stallCycles++;
      if (bus.dataout_valid) dvDuringBusy++;
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput("mfhi stall cycles", 32'(stallCycles), 32'd32);
    checkOutput("mfhi no early dv", 32'(dvDuringBusy), 32'd0);
    checkOutput("stall low in IDLE", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    checkOutput("mfhi after div dv", {31'b0, bus.dataout_valid}, 32'h1);
    checkOutput("mfhi after div dataout", bus.dataout, 32'd2);

    // No-op codes during MUL never stall; a real HI/LO op does.
    applyStimulus(OP_MULTU, 32'd3, 32'd5);
    bus.op_valid = 1'b1;
    bus.op       = OP_NOP;
    #1;
    checkOutput("nop 0000 stall", {31'b0, bus.stall}, 32'h0);
    bus.op = 4'b1111;
    #1;
    checkOutput("nop 1111 stall", {31'b0, bus.stall}, 32'h0);
    bus.op = OP_MTLO;
    #1;
    checkOutput("mtlo busy stall", {31'b0, bus.stall}, 32'h1);
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    waitDone(cycles);
    checkOutput("mul 3x5 lo", bus.lo, 32'd15);
    checkOutput("mul 3x5 hi", bus.hi, 32'd0);

    // Reset at iteration 10 of a MULTU aborts it and clears HI/LO.
    applyStimulus(OP_MTHI, 32'hAAAA_0001, 32'h0);
    applyStimulus(OP_MULTU, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy before abort", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("abort hi", bus.hi, 32'h0);
    checkOutput("abort lo", bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after abort hi", bus.hi, 32'h0);
    applyStimulus(OP_MULTU, 32'd3, 32'd5);
    waitDone(cycles);
    checkOutput("post-reset busy cycles", 32'(cycles), 32'd32);
    checkOutput("post-reset lo", bus.lo, 32'd15);
    checkOutput("post-reset hi", bus.hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
